// File: rtl/secuenciador_programa.sv
// Program sequencer: fetches instructions over a req/ack handshake, issues them
// to the register bank for one cycle and sequences data-memory loads/stores.
module secuenciador_programa #(
  parameter int ANCHO_PC  = 8,
  parameter int ANCHO_INS = 9
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Habilitar,
  output logic                 o_Mem_Req,
  output logic [ANCHO_PC-1:0]  o_Mem_Dir,
  input  logic                 i_Mem_Ack,
  input  logic [ANCHO_INS-1:0] i_Mem_Dato,
  input  logic [ANCHO_PC-1:0]  i_Direccion_Salto,
  output logic [ANCHO_INS-1:0] o_Instrucciones,
  output logic [ANCHO_PC-1:0]  o_Direccion_PC,
  output logic                 o_Control_Registros,
  output logic                 o_Lectura_Dato,
  output logic                 o_Escritura_Dato,
  input  logic                 i_Dato_Listo,
  output logic [ANCHO_PC-1:0]  o_PC,
  output logic [15:0]          o_Retiradas
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] DATO  = 2'd3;

  localparam logic [2:0] OP_CARGA  = 3'b010;
  localparam logic [2:0] OP_ALM_A  = 3'b011;
  localparam logic [2:0] OP_ALM_B  = 3'b100;
  localparam logic [2:0] OP_ALU    = 3'b110;
  localparam logic [2:0] OP_SALTO  = 3'b111;

  logic [1:0]           r_Estado;
  logic [ANCHO_PC-1:0]  r_PC;
  logic [ANCHO_INS-1:0] r_IR;
  logic [15:0]          r_Retiradas;

  logic [2:0]           w_Op;
  logic                 w_Es_Mem;
  logic                 w_Es_Almacen;
  logic                 w_Completa;
  logic [ANCHO_PC-1:0]  w_PC_Mas1;

  assign w_Op         = r_IR[ANCHO_INS-1 -: 3];
  assign w_Es_Almacen = (w_Op == OP_ALM_A) || (w_Op == OP_ALM_B);
  assign w_Es_Mem     = (w_Op == OP_CARGA) || w_Es_Almacen;
  assign w_PC_Mas1    = r_PC + ANCHO_PC'(1);

  // An instruction retires at the end of EXEC, or on data-ready for memory ops.
  assign w_Completa = ((r_Estado == EXEC) && !w_Es_Mem) ||
                      ((r_Estado == DATO) && i_Dato_Listo);

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_Estado    <= IDLE;
      r_PC        <= '0;
      r_IR        <= '0;
      r_Retiradas <= '0;
    end else begin
      case (r_Estado)
        IDLE: begin
          if (i_Habilitar) r_Estado <= FETCH;
        end
        FETCH: begin
          if (i_Mem_Ack) begin
            r_IR     <= i_Mem_Dato;
            r_Estado <= EXEC;
          end
        end
        EXEC: begin
          if (w_Es_Mem) r_Estado <= DATO;
          else if (w_Op == OP_SALTO) r_PC <= i_Direccion_Salto;
          else r_PC <= w_PC_Mas1;
        end
        DATO: begin
          if (i_Dato_Listo) r_PC <= w_PC_Mas1;
        end
        default: r_Estado <= IDLE;
      endcase
      if (w_Completa) begin
        r_Retiradas <= r_Retiradas + 16'd1;
        r_Estado    <= i_Habilitar ? FETCH : IDLE;
      end
    end
  end

  assign o_Mem_Req = (r_Estado == FETCH);
  assign o_Mem_Dir = r_PC;
  assign o_PC      = r_PC;
  assign o_Retiradas    = r_Retiradas;
  assign o_Direccion_PC = w_PC_Mas1;

  // Loads re-present the instruction on the ready cycle so the bank captures the data.
  assign o_Instrucciones = ((r_Estado == EXEC) ||
                            ((r_Estado == DATO) && (w_Op == OP_CARGA) && i_Dato_Listo))
                           ? r_IR : '0;

  assign o_Control_Registros = (r_Estado == EXEC) && (w_Op == OP_ALU);
  assign o_Lectura_Dato      = (r_Estado == EXEC) && (w_Op == OP_CARGA);
  assign o_Escritura_Dato    = (r_Estado == EXEC) && w_Es_Almacen;

endmodule
